// File: rtl/crossbar_pkg.sv
// Shared types and helpers for the crossbar per-output packet arbiter.
package crossbar_pkg;

  // Per-output arbitration state: IDLE waits for a request, BUSY holds a locked grant.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Increment modulo count with an explicit wrap, so count need not be a power of two.
  function automatic int mod_inc(input int value, input int count);
    if (value + 1 >= count) begin
      return 0;
    end
    return value + 1;
  endfunction

endpackage

// File: rtl/crossbar_rr_arbiter_unit.sv
// Round-robin packet arbiter for a single crossbar output.
// Grants one requesting input, locks the grant until the end-of-packet
// handshake, then rotates the priority pointer past the served input.
// Handshake: req_i is a level request per input; eop_i is the qualified
// last-beat transfer (valid && ready && last) of the granted input. A grant
// only changes on eop_i, and a released output spends one cycle in IDLE.
module rr_arbiter_unit
  import crossbar_pkg::*;
#(
  parameter int S_DATA_COUNT = 2,
  parameter int ID_W         = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [S_DATA_COUNT-1:0] req_i,
  input  logic                    eop_i,
  output logic [ID_W-1:0]         grant_o,
  output logic                    grant_valid_o,
  output arb_state_t              state_o
);

  arb_state_t      state_q;
  arb_state_t      state_d;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic [ID_W-1:0] grant_q;
  logic [ID_W-1:0] grant_d;
  logic            valid_q;
  logic            valid_d;
  logic [ID_W-1:0] winner;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: claim on any request, release only on end of packet.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_i) state_d = BUSY;
      BUSY:    if (eop_i)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Winner search: first request at or above ptr_q, wrapping around.
  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = ptr_q;
    for (int i = 0; i < S_DATA_COUNT; i++) begin
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = ID_W'(mod_inc(int'(idx), S_DATA_COUNT));
    end
  end

  // Output and pointer updates, keyed on the current state.
  always_comb begin
    grant_d = grant_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE && |req_i) begin
      grant_d = winner;
      valid_d = 1'b1;
    end else if (state_q == BUSY && eop_i) begin
      grant_d = '0;
      valid_d = 1'b0;
      ptr_d   = ID_W'(mod_inc(int'(grant_q), S_DATA_COUNT));
    end
  end

  // Grant, grant-valid and pointer registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      grant_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = valid_q;
  assign state_o       = state_q;

endmodule

// File: rtl/crossbar_arbiter.sv
// Per-output packet arbiter for the stream crossbar. Builds the request and
// end-of-packet terms for each output and runs one round-robin unit per output.
// Outputs are independent: an input has one destination at a time.
module crossbar_arbiter
  import crossbar_pkg::*;
#(
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3,
  parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_n_i,
  input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]                   s_last_i,
  input  logic [S_DATA_COUNT-1:0]                   s_valid_i,
  input  logic [M_DATA_COUNT-1:0]                   m_ready_i,
  output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] grant_o,
  output logic [M_DATA_COUNT-1:0]                   grant_valid_o,
  output arb_state_t [M_DATA_COUNT-1:0]             state_o
);

  for (genvar m = 0; m < M_DATA_COUNT; m++) begin : g_out
    localparam logic [T_DEST_WIDTH-1:0] M_IDX = T_DEST_WIDTH'(m);

    logic [S_DATA_COUNT-1:0] req;
    logic                    eop;
    logic [T_ID___WIDTH-1:0] g;

    assign g = grant_o[m];

    // Requests: valid inputs whose destination is this output.
    always_comb begin
      for (int s = 0; s < S_DATA_COUNT; s++) begin
        req[s] = s_valid_i[s] && (s_dest_i[s] == M_IDX);
      end
    end

    // Last-beat handshake of the granted input on this output.
    assign eop = s_valid_i[g] && (s_dest_i[g] == M_IDX) && m_ready_i[m] && s_last_i[g];

    rr_arbiter_unit #(
      .S_DATA_COUNT (S_DATA_COUNT),
      .ID_W         (T_ID___WIDTH)
    ) u_unit (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .req_i         (req),
      .eop_i         (eop),
      .grant_o       (grant_o[m]),
      .grant_valid_o (grant_valid_o[m]),
      .state_o       (state_o[m])
    );
  end

endmodule

// File: tb/tb_crossbar_arbiter.sv
// Directed bench for crossbar_arbiter (2 inputs, 3 outputs).
// Observed value per check is {grant_valid_o[2:0], grant_o[2:0]}.
module tb_crossbar_arbiter;
  import crossbar_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic [1:0][1:0]      s_dest;
  logic [1:0]           s_last;
  logic [1:0]           s_valid;
  logic [2:0]           m_ready;
  logic [2:0][0:0]      grant;
  logic [2:0]           grant_valid;
  arb_state_t [2:0]     state;

  int checks = 0;
  int errors = 0;

  crossbar_arbiter #(
    .S_DATA_COUNT (2),
    .M_DATA_COUNT (3)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .s_dest_i      (s_dest),
    .s_last_i      (s_last),
    .s_valid_i     (s_valid),
    .m_ready_i     (m_ready),
    .grant_o       (grant),
    .grant_valid_o (grant_valid),
    .state_o       (state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_valid = '0;
    s_last  = '0;
    s_dest  = '0;
    m_ready = '1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 2'($urandom_range(0, 3));
    s_last  = 2'($urandom_range(0, 3));
    s_dest  = 4'($urandom_range(0, 15));
    m_ready = 3'($urandom_range(0, 7));
    step();
    step();
    checks++;
    if ({grant_valid, grant} !== 6'b000_000 || state !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %b state %b want 000000 state 000", {grant_valid, grant}, state);
    end
    idle_inputs();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_stream();
    s_valid = 2'b01; s_dest[0] = 2'd2; s_last = 2'b00;
    step();
    checks++;
    if ({grant_valid, grant} !== 6'b100_000) begin
      errors++; $display("FAIL single_grant: got %b want 100000", {grant_valid, grant});
    end
    step();
    checks++;
    if ({grant_valid, grant} !== 6'b100_000) begin
      errors++; $display("FAIL single_beat1: got %b want 100000", {grant_valid, grant});
    end
    step();
    checks++;
    if ({grant_valid, grant} !== 6'b100_000) begin
      errors++; $display("FAIL single_beat2: got %b want 100000", {grant_valid, grant});
    end
    s_last = 2'b01;
    step();
    checks++;
    if ({grant_valid, grant} !== 6'b000_000) begin
      errors++; $display("FAIL single_release: got %b want 000000", {grant_valid, grant});
    end
    idle_inputs();
    step();
  endtask

  task automatic test_contention();
    logic [5:0] exp_seq [8];
    exp_seq = '{6'b010_000, 6'b000_000, 6'b010_010, 6'b000_000,
                6'b010_000, 6'b000_000, 6'b010_010, 6'b000_000};
    s_valid = 2'b11; s_dest[0] = 2'd1; s_dest[1] = 2'd1; s_last = 2'b11;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({grant_valid, grant} !== exp_seq[i]) begin
        errors++;
        $display("FAIL contention_%0d: got %b want %b", i, {grant_valid, grant}, exp_seq[i]);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_backpressure();
    s_valid = 2'b10; s_dest[1] = 2'd1; s_last = 2'b10; m_ready = 3'b101;
    step();
    checks++;
    if ({grant_valid, grant} !== 6'b010_010) begin
      errors++; $display("FAIL bp_grant: got %b want 010010", {grant_valid, grant});
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({grant_valid, grant} !== 6'b010_010) begin
        errors++; $display("FAIL bp_hold_%0d: got %b want 010010", i, {grant_valid, grant});
      end
    end
    m_ready = 3'b111;
    step();
    checks++;
    if ({grant_valid, grant} !== 6'b000_000) begin
      errors++; $display("FAIL bp_release: got %b want 000000", {grant_valid, grant});
    end
    idle_inputs();
    step();
  endtask

  task automatic test_lock_dest_change();
    s_valid = 2'b01; s_dest[0] = 2'd0; s_last = 2'b00;
    step();
    checks++;
    if ({grant_valid, grant} !== 6'b001_000) begin
      errors++; $display("FAIL lock_grant: got %b want 001000", {grant_valid, grant});
    end
    // s0 retargets output 2 while paused with last set: no release, no new grant.
    s_valid = 2'b00; s_dest[0] = 2'd2; s_last = 2'b01;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({grant_valid, grant} !== 6'b001_000 || state !== {IDLE, IDLE, BUSY}) begin
        errors++;
        $display("FAIL lock_hold_%0d: got %b state %b want 001000 state 001", i, {grant_valid, grant}, state);
      end
    end
    s_valid = 2'b01; s_dest[0] = 2'd0; s_last = 2'b01;
    step();
    checks++;
    if ({grant_valid, grant} !== 6'b000_000) begin
      errors++; $display("FAIL lock_release: got %b want 000000", {grant_valid, grant});
    end
    s_dest[0] = 2'd2; s_last = 2'b00;
    step();
    checks++;
    if ({grant_valid, grant} !== 6'b100_000) begin
      errors++; $display("FAIL lock_out2_after: got %b want 100000", {grant_valid, grant});
    end
    s_last = 2'b01;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_parallel();
    s_valid = 2'b11; s_dest[0] = 2'd0; s_dest[1] = 2'd1; s_last = 2'b11;
    step();
    checks++;
    if ({grant_valid, grant} !== 6'b011_010) begin
      errors++; $display("FAIL parallel_grant: got %b want 011010", {grant_valid, grant});
    end
    step();
    checks++;
    if ({grant_valid, grant} !== 6'b000_000) begin
      errors++; $display("FAIL parallel_release: got %b want 000000", {grant_valid, grant});
    end
    idle_inputs();
    step();
  endtask

  task automatic test_bad_dest();
    s_valid = 2'b01; s_dest[0] = 2'd3; s_last = 2'b01;
    step();
    step();
    checks++;
    if ({grant_valid, grant} !== 6'b000_000) begin
      errors++; $display("FAIL bad_dest: got %b want 000000", {grant_valid, grant});
    end
    idle_inputs();
    step();
  endtask

  task automatic test_async_reset();
    s_valid = 2'b10; s_dest[1] = 2'd2; s_last = 2'b00;
    step();
    checks++;
    if ({grant_valid, grant} !== 6'b100_100) begin
      errors++; $display("FAIL async_pre_grant: got %b want 100100", {grant_valid, grant});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({grant_valid, grant} !== 6'b000_000 || state !== '0) begin
      errors++;
      $display("FAIL async_clear: got %b state %b want 000000 state 000", {grant_valid, grant}, state);
    end
    step();
    checks++;
    if ({grant_valid, grant} !== 6'b000_000) begin
      errors++; $display("FAIL async_hold: got %b want 000000", {grant_valid, grant});
    end
    idle_inputs();
    rst_n = 1'b1;
    step();
  endtask

  // Test sequence and final report.
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_stream();
    test_contention();
    test_backpressure();
    test_lock_dest_change();
    test_parallel();
    test_bad_dest();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
